// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI byte shifter: FSM encoding,
// status bit positions and the minimum SCK half-period.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCK_LO = 2'd1,
        ST_SCK_HI = 2'd2,
        ST_DONE   = 2'd3
    } sd_state_t;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_OVR    = 2;

    localparam int MIN_HALF    = 1;
    localparam int SYNC_STAGES = 2;
    localparam int MISO_STAGES = 1;

endpackage

// File: rtl/sd_sync_edge.sv
// Flop chain bringing an asynchronous level into the sys_clk domain,
// with a rising-edge pulse derived from one extra flop.
module sd_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] sync_p0;
    logic              sync_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_p0[i] <= sync_p0[i-1];
            end
            sync_p1 <= sync_p0[STAGES-1];
        end
    end

    assign sync = sync_p0[STAGES-1];
    assign rise = sync_p0[STAGES-1] & ~sync_p1;

endmodule

// File: rtl/sd_spi_shift.sv
// SPI mode-0, MSB-first byte shifter for an SD card, started by a rising
// edge on the MCU shift request and paced by a programmable SCK half-period.
module sd_spi_shift
    import sd_pkg::*;
(
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       sspshif_i,
    input  logic [7:0] ssppres_i8,
    input  logic [7:0] ssptdat_i8,
    output logic [7:0] ssprdat_o8,
    output logic [7:0] sspstat_o8,
    output logic       sd_sck_o,
    output logic       sd_mosi_o,
    input  logic       sd_miso_i
);

    sd_state_t   state_q, state_d;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  half_q;
    logic [7:0]  tx_q;
    logic [7:0]  rx_q;
    logic [7:0]  rdat_q;
    logic        done_q;
    logic        ovr_q;
    logic        phase_end;
    logic        shif_rise;
    logic        shif_sync_unused;
    logic        miso_smp;
    logic        miso_rise_unused;
    logic [7:0]  stat_d;

    function automatic logic [7:0] sat_half(input logic [7:0] pres);
        return (pres == 8'd0) ? 8'(MIN_HALF) : pres;
    endfunction

    sd_sync_edge #(.STAGES(SYNC_STAGES)) u_shif_sync (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_n_i),
        .din   (sspshif_i),
        .sync  (shif_sync_unused),
        .rise  (shif_rise)
    );

    // Single sampling flop: the value it captures on the edge entering SCK_HI is used.
    sd_sync_edge #(.STAGES(MISO_STAGES)) u_miso_smp (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_n_i),
        .din   (sd_miso_i),
        .sync  (miso_smp),
        .rise  (miso_rise_unused)
    );

    assign phase_end = (cnt_q == ({8'd0, half_q} - 16'd1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (shif_rise) state_d = ST_SCK_LO;
            ST_SCK_LO: if (phase_end) state_d = ST_SCK_HI;
            ST_SCK_HI: if (phase_end) state_d = (bit_q == 3'd7) ? ST_DONE : ST_SCK_LO;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            half_q  <= 8'(MIN_HALF);
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            rdat_q  <= 8'h00;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= 16'd0;
            end else if (state_q == ST_SCK_LO || state_q == ST_SCK_HI) begin
                cnt_q <= cnt_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (shif_rise) begin
                        tx_q   <= ssptdat_i8;
                        half_q <= sat_half(ssppres_i8);
                        bit_q  <= 3'd0;
                        done_q <= 1'b0;
                        ovr_q  <= 1'b0;
                    end
                end
                ST_SCK_HI: begin
                    if (cnt_q == 16'd0) rx_q <= {rx_q[6:0], miso_smp};
                    if (phase_end) begin
                        tx_q  <= {tx_q[6:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    rdat_q <= rx_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase

            // Any edge seen outside IDLE, including the DONE cycle, is dropped.
            if (shif_rise && state_q != ST_IDLE) ovr_q <= 1'b1;
        end
    end

    always_comb begin
        stat_d            = 8'h00;
        stat_d[STAT_BUSY] = (state_q != ST_IDLE);
        stat_d[STAT_DONE] = done_q;
        stat_d[STAT_OVR]  = ovr_q;
    end

    assign sspstat_o8 = stat_d;
    assign ssprdat_o8 = rdat_q;
    assign sd_sck_o   = (state_q == ST_SCK_HI);
    assign sd_mosi_o  = (state_q == ST_SCK_LO || state_q == ST_SCK_HI) ? tx_q[7] : 1'b1;

endmodule
